// File: rtl/riscv_instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
//   instr_fmt_t : descriptor format code (R/I/S/B/U/J; 6 and 7 are illegal)
//   OPC_*       : RV32I major opcodes
//   enc_state_t : encoder FSM state
package riscv_instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ERR  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/riscv_instr_encoder_if.sv
// Descriptor request channel and IMEM write port of the instruction encoder.
//   req_*  : valid/ready descriptor stream into the encoder
//   imem_* : registered IMEM write port out of the encoder
// master = program source / IMEM side, slave = encoder.
interface riscv_instr_encoder_if #(
  parameter int IMEM_AW = 8
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [2:0]         req_fmt_i;
  logic [6:0]         req_opcode_i;
  logic [2:0]         req_funct3_i;
  logic [6:0]         req_funct7_i;
  logic [4:0]         req_rd_i;
  logic [4:0]         req_rs1_i;
  logic [4:0]         req_rs2_i;
  logic [31:0]        req_imm_i;
  logic               req_last_i;
  logic               imem_wr_en_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_wdata_o;

  modport master (
    output req_valid_i, req_fmt_i, req_opcode_i, req_funct3_i, req_funct7_i,
           req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, req_last_i,
    input  req_ready_o, imem_wr_en_o, imem_addr_o, imem_wdata_o
  );

  modport slave (
    input  req_valid_i, req_fmt_i, req_opcode_i, req_funct3_i, req_funct7_i,
           req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, req_last_i,
    output req_ready_o, imem_wr_en_o, imem_addr_o, imem_wdata_o
  );
endinterface

// File: rtl/riscv_instr_pack.sv
// Combinational RV32I instruction packer.
//   i_fmt             : format code (instr_fmt_t encoding)
//   i_opcode..i_imm   : descriptor fields; fields unused by a format are ignored
//   o_word            : packed 32-bit instruction (0 when the format is illegal)
//   o_legal           : 1 when i_fmt is one of R/I/S/B/U/J
module riscv_instr_pack
  import riscv_instr_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  // SLLI/SRLI/SRAI carry funct7 in the upper bits and a 5-bit shamt.
  logic w_is_shift;
  assign w_is_shift = (i_opcode == OPC_OPIMM) &&
                      ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (i_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        if (w_is_shift)
          o_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        else
          o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                       i_rd, i_opcode};
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_instr_encoder.sv
// Program loader: packs descriptors into RV32I words and writes them to
// consecutive IMEM word addresses starting at BASE_ADDR.
//   clk, reset : clock, synchronous active-high reset
//   start_i    : begin a load session (honoured in IDLE or ERR)
//   bus        : descriptor stream in, registered IMEM write port out
//   busy_o     : high while loading
//   done_o     : pulses with the write of the last word
//   err_o      : sticky overflow / illegal-format flag, cleared by start_i
//
// state   | meaning
// IDLE    | waiting for start_i, not accepting descriptors
// LOAD    | accepting one descriptor per cycle
// ERR     | overflow or illegal format seen; waiting for start_i or reset
module riscv_instr_encoder
  import riscv_instr_encoder_pkg::*;
#(
  parameter int IMEM_AW   = 8,
  parameter int BASE_ADDR = 0
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  riscv_instr_encoder_if.slave  bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [IMEM_AW-1:0] C_BASE = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW-1:0] C_TOP  = {IMEM_AW{1'b1}};

  enc_state_t         r_state, w_next;
  logic [IMEM_AW-1:0] r_cnt;
  logic [IMEM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic               r_wr_en, r_done, r_err;

  logic [31:0] w_word;
  logic        w_legal, w_ready, w_accept, w_write;

  riscv_instr_pack u_pack (
    .i_fmt    (bus.req_fmt_i),
    .i_opcode (bus.req_opcode_i),
    .i_funct3 (bus.req_funct3_i),
    .i_funct7 (bus.req_funct7_i),
    .i_rd     (bus.req_rd_i),
    .i_rs1    (bus.req_rs1_i),
    .i_rs2    (bus.req_rs2_i),
    .i_imm    (bus.req_imm_i),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  assign w_ready  = (r_state == ST_LOAD);
  assign w_accept = w_ready && bus.req_valid_i;
  assign w_write  = w_accept && w_legal;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_accept) begin
          if (!w_legal)              w_next = ST_ERR;
          else if (bus.req_last_i)   w_next = ST_IDLE;
          else if (r_cnt == C_TOP)   w_next = ST_ERR;  // no room for the next word
        end
      end
      ST_ERR:  if (start_i) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= C_BASE;
      r_addr  <= C_BASE;
      r_wdata <= '0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_write;
      r_done  <= w_write && bus.req_last_i;
      r_err   <= (w_next == ST_ERR);
      if (r_state != ST_LOAD && start_i)
        r_cnt <= C_BASE;
      if (w_write) begin
        r_addr  <= r_cnt;
        r_wdata <= w_word;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready_o  = w_ready;
  assign bus.imem_wr_en_o = r_wr_en;
  assign bus.imem_addr_o  = r_addr;
  assign bus.imem_wdata_o = r_wdata;
  assign busy_o           = (r_state == ST_LOAD);
  assign done_o           = r_done;
  assign err_o            = r_err;

endmodule
